// File: rtl/stage2_id_hz.sv
// stage2_id_hz: parametrised MIPS instruction-decode stage with register file, load-use stall,
// flush bubbles and a saturating stall counter. Optional macro ID_WRITE_BYPASS_EN: same-cycle WB->ID bypass.
module stage2_id_hz #(
  parameter int DW    = 32,
  parameter int NREGS = 32,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     inst,
  input  logic [DW-1:0]   pc4,
  input  logic            flush,
  input  logic            regwrite,
  input  logic [4:0]      wrreg,
  input  logic [DW-1:0]   wrdata,
  output logic            stall,
  output logic            valid,
  output logic [DW-1:0]   pc4_out,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [DW-1:0]   seimm,
  output logic [DW-1:0]   data1,
  output logic [DW-1:0]   data2,
  output logic            regdst,
  output logic            branch,
  output logic            memread,
  output logic            memtoreg,
  output logic            memwrite,
  output logic            alusrc,
  output logic            regwrite_out,
  output logic [1:0]      aluop,
  output logic [DW-1:0]   id_regrs,
  output logic [DW-1:0]   id_regrt,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int              AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0]      NREGS_V = 6'(NREGS);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  logic [DW-1:0]   regs_r [NREGS];
  ctrl_t           ctrl_s;
  ctrl_t           ctrl_r;
  logic            valid_r;
  logic            hazard_s;
  logic            stall_s;
  logic            we_s;
  logic [DW-1:0]   pc4_r;
  logic [DW-1:0]   seimm_r;
  logic [DW-1:0]   data1_r;
  logic [DW-1:0]   data2_r;
  logic [DW-1:0]   seimm_s;
  logic [DW-1:0]   rs_val_s;
  logic [DW-1:0]   rt_val_s;
  logic [4:0]      rt_r;
  logic [4:0]      rd_r;
  logic [CNTW-1:0] stall_cnt_r;

  // Index 0 and indices beyond the implemented file are hardwired to zero.
  function automatic logic reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < NREGS_V);
  endfunction

  function automatic logic [DW-1:0] rf_read(input logic [4:0] idx);
    logic [DW-1:0] val;
    if (!reg_ok(idx)) begin
      val = '0;
`ifdef ID_WRITE_BYPASS_EN
    end else if (regwrite && (wrreg == idx)) begin
      val = wrdata;
`endif
    end else begin
      val = regs_r[idx[AW-1:0]];
    end
    return val;
  endfunction

  assign we_s    = regwrite & reg_ok(wrreg);
  assign seimm_s = DW'($signed(inst[15:0]));

  // Register file write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we_s) begin
      regs_r[wrreg[AW-1:0]] <= wrdata;
    end
  end

  // Register file read ports for $rs and $rt.
  always_comb begin
    rs_val_s = rf_read(inst[25:21]);
    rt_val_s = rf_read(inst[20:16]);
  end

  // Opcode to control decode.
  always_comb begin
    ctrl_s = '0;
    case (inst[31:26])
      6'h00: begin
        ctrl_s.regdst   = 1'b1;
        ctrl_s.regwrite = 1'b1;
        ctrl_s.aluop    = 2'd2;
      end
      6'h23: begin
        ctrl_s.alusrc   = 1'b1;
        ctrl_s.memread  = 1'b1;
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regwrite = 1'b1;
        ctrl_s.aluop    = 2'd0;
      end
      6'h2b: begin
        ctrl_s.alusrc   = 1'b1;
        ctrl_s.memwrite = 1'b1;
        ctrl_s.aluop    = 2'd0;
      end
      6'h04: begin
        ctrl_s.branch = 1'b1;
        ctrl_s.aluop  = 2'd1;
      end
      default: ctrl_s = '0;
    endcase
  end

  // Load-use detection against the load currently in EX; a flush overrides the stall.
  always_comb begin
    hazard_s = ctrl_r.memread & valid_r & (rt_r != 5'd0) &
               ((rt_r == inst[25:21]) | (rt_r == inst[20:16]));
    stall_s  = hazard_s & ~flush;
  end

  // ID/EX pipeline bank; flush or hazard injects a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      pc4_r   <= '0;
      rt_r    <= 5'd0;
      rd_r    <= 5'd0;
      seimm_r <= '0;
      data1_r <= '0;
      data2_r <= '0;
    end else begin
      pc4_r   <= pc4;
      rt_r    <= inst[20:16];
      rd_r    <= inst[15:11];
      seimm_r <= seimm_s;
      data1_r <= rs_val_s;
      data2_r <= rt_val_s;
      if (flush || hazard_s) begin
        valid_r <= 1'b0;
        ctrl_r  <= '0;
      end else begin
        valid_r <= 1'b1;
        ctrl_r  <= ctrl_s;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNTW'(1);
    end
  end

  assign stall        = stall_s;
  assign valid        = valid_r;
  assign pc4_out      = pc4_r;
  assign rt           = rt_r;
  assign rd           = rd_r;
  assign seimm        = seimm_r;
  assign data1        = data1_r;
  assign data2        = data2_r;
  assign regdst       = ctrl_r.regdst;
  assign branch       = ctrl_r.branch;
  assign memread      = ctrl_r.memread;
  assign memtoreg     = ctrl_r.memtoreg;
  assign memwrite     = ctrl_r.memwrite;
  assign alusrc       = ctrl_r.alusrc;
  assign regwrite_out = ctrl_r.regwrite;
  assign aluop        = ctrl_r.aluop;
  assign id_regrs     = rs_val_s;
  assign id_regrt     = rt_val_s;
  assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_stage2_id_hz.sv
// tb_stage2_id_hz: scoreboard bench for stage2_id_hz; a default 32/32/16 instance and a
// small 16/8/2 instance. Expected ID/EX contents are queued at issue and popped after the edge.
`timescale 1ns/1ps
module tb_stage2_id_hz;

  typedef struct packed {
    logic        valid;
    logic        regdst;
    logic        branch;
    logic        memread;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regwrite;
    logic [1:0]  aluop;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] seimm;
    logic [31:0] data1;
    logic [31:0] data2;
  } idex_t;

  typedef struct {
    logic [31:0] i;
    logic        f;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
  } row_t;

  logic clk = 1'b0;
  logic reset;

  logic [31:0] inst, pc4, wrdata, pc4_out, seimm, data1, data2, id_regrs, id_regrt;
  logic        flush, regwrite, stall, valid;
  logic [4:0]  wrreg, rt, rd;
  logic        regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite_out;
  logic [1:0]  aluop;
  logic [15:0] stall_cnt;

  logic [31:0] b_inst;
  logic [15:0] b_pc4, b_wrdata, b_pc4_out, b_seimm, b_data1, b_data2, b_id_regrs, b_id_regrt;
  logic        b_flush, b_regwrite, b_stall, b_valid;
  logic [4:0]  b_wrreg, b_rt, b_rd;
  logic        b_regdst, b_branch, b_memread, b_memtoreg, b_memwrite, b_alusrc, b_regwrite_out;
  logic [1:0]  b_aluop;
  logic [1:0]  b_stall_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [32];
  idex_t       prev_exp;
  idex_t       sb_q [$];
  logic        exp_stall;
  logic [31:0] exp_r1, exp_r2, pc4_v;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  stage2_id_hz #(.DW(32), .NREGS(32), .CNTW(16)) dut_a (
    .clk(clk), .reset(reset), .inst(inst), .pc4(pc4), .flush(flush),
    .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata), .stall(stall), .valid(valid),
    .pc4_out(pc4_out), .rt(rt), .rd(rd), .seimm(seimm), .data1(data1), .data2(data2),
    .regdst(regdst), .branch(branch), .memread(memread), .memtoreg(memtoreg),
    .memwrite(memwrite), .alusrc(alusrc), .regwrite_out(regwrite_out), .aluop(aluop),
    .id_regrs(id_regrs), .id_regrt(id_regrt), .stall_cnt(stall_cnt)
  );

  stage2_id_hz #(.DW(16), .NREGS(8), .CNTW(2)) dut_b (
    .clk(clk), .reset(reset), .inst(b_inst), .pc4(b_pc4), .flush(b_flush),
    .regwrite(b_regwrite), .wrreg(b_wrreg), .wrdata(b_wrdata), .stall(b_stall), .valid(b_valid),
    .pc4_out(b_pc4_out), .rt(b_rt), .rd(b_rd), .seimm(b_seimm), .data1(b_data1), .data2(b_data2),
    .regdst(b_regdst), .branch(b_branch), .memread(b_memread), .memtoreg(b_memtoreg),
    .memwrite(b_memwrite), .alusrc(b_alusrc), .regwrite_out(b_regwrite_out), .aluop(b_aluop),
    .id_regrs(b_id_regrs), .id_regrt(b_id_regrt), .stall_cnt(b_stall_cnt)
  );

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
`ifdef ID_WRITE_BYPASS_EN
    if (we && (wr == idx)) return wd;
`endif
    return model[idx];
  endfunction

  function automatic idex_t sample_a();
    idex_t o;
    o.valid = valid;       o.regdst = regdst;     o.branch = branch;
    o.memread = memread;   o.memtoreg = memtoreg; o.memwrite = memwrite;
    o.alusrc = alusrc;     o.regwrite = regwrite_out; o.aluop = aluop;
    o.rt = rt;             o.rd = rd;             o.pc4 = pc4_out;
    o.seimm = seimm;       o.data1 = data1;       o.data2 = data2;
    return o;
  endfunction

  // Drive one ID-stage cycle and queue the ID/EX contents it should produce.
  task automatic set_inputs(input row_t r);
    idex_t e;
    logic  hz;
    pc4_v    = pc4_v + 32'd4;
    inst     = r.i;  flush = r.f;  regwrite = r.we;  wrreg = r.wr;  wrdata = r.wd;  pc4 = pc4_v;
    hz = prev_exp.memread && prev_exp.valid && (prev_exp.rt != 5'd0) &&
         ((prev_exp.rt == r.i[25:21]) || (prev_exp.rt == r.i[20:16]));
    exp_stall = hz && !r.f;
    exp_r1 = mread(r.i[25:21], r.we, r.wr, r.wd);
    exp_r2 = mread(r.i[20:16], r.we, r.wr, r.wd);
    e = '0;
    e.valid = !(r.f || hz);
    if (e.valid) begin
      case (r.i[31:26])
        6'h00: begin e.regdst = 1'b1; e.regwrite = 1'b1; e.aluop = 2'd2; end
        6'h23: begin e.alusrc = 1'b1; e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; end
        6'h2b: begin e.alusrc = 1'b1; e.memwrite = 1'b1; end
        6'h04: begin e.branch = 1'b1; e.aluop = 2'd1; end
        default: ;
      endcase
    end
    e.rt = r.i[20:16];  e.rd = r.i[15:11];  e.pc4 = pc4_v;
    e.seimm = {{16{r.i[15]}}, r.i[15:0]};
    e.data1 = exp_r1;   e.data2 = exp_r2;
    sb_q.push_back(e);
    prev_exp = e;
    if (exp_stall && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (regwrite && (wrreg != 5'd0)) model[wrreg] = wrdata;
    #1;
  endtask

  task automatic reset_model();
    foreach (model[k]) model[k] = 32'd0;
    prev_exp = '0;
    exp_cnt  = 16'd0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;  inst = 32'd0;  pc4 = 32'd0;  flush = 1'b0;  regwrite = 1'b0;
    wrreg = 5'd0;  wrdata = 32'd0;  pc4_v = 32'd0;
    b_inst = 32'd0;  b_pc4 = 16'h0040;  b_flush = 1'b0;  b_regwrite = 1'b0;
    b_wrreg = 5'd0;  b_wrdata = 16'd0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sample_a(), stall, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h exp 0", {sample_a(), stall, stall_cnt});
    end
    checks++;
    if ({b_valid, b_stall, b_stall_cnt, b_data1, b_seimm, b_regwrite_out} !== '0) begin
      errors++;
      $display("FAIL reset_b: valid=%b stall=%b cnt=%0d data1=%h seimm=%h", b_valid, b_stall, b_stall_cnt, b_data1, b_seimm);
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    row_t  rows [5];
    idex_t exp;
    rows[0] = '{32'hFC00_0000, 1'b0, 1'b1, 5'd5, 32'h0000_1234};  // write $5
    rows[1] = '{32'h00A0_1820, 1'b0, 1'b0, 5'd0, 32'd0};          // add $3,$5,$0
    rows[2] = '{32'hAC05_0008, 1'b0, 1'b0, 5'd0, 32'd0};          // sw $5,8($0)
    rows[3] = '{32'h10A5_FFFF, 1'b0, 1'b0, 5'd0, 32'd0};          // beq $5,$5,-1
    rows[4] = '{32'hFC00_8001, 1'b0, 1'b0, 5'd0, 32'd0};          // unknown opcode, imm 0x8001
    foreach (rows[k]) begin
      set_inputs(rows[k]);
      #1;
      checks++;
      if ({stall, id_regrs, id_regrt} !== {exp_stall, exp_r1, exp_r2}) begin
        errors++;
        $display("FAIL rtype_comb[%0d]: got stall=%b rs=%h rt=%h exp stall=%b rs=%h rt=%h", k, stall, id_regrs, id_regrt, exp_stall, exp_r1, exp_r2);
      end
      edge_step();
      exp = sb_q.pop_front();
      checks++;
      if ({sample_a(), stall_cnt} !== {exp, exp_cnt}) begin
        errors++;
        $display("FAIL rtype_idex[%0d]: got %h exp %h", k, {sample_a(), stall_cnt}, {exp, exp_cnt});
      end
    end
  endtask

  task automatic test_load_use();
    row_t  rows [11];
    idex_t exp;
    rows[0]  = '{32'hFC00_0000, 1'b0, 1'b1, 5'd9, 32'h0000_0100};  // write $9
    rows[1]  = '{32'h8D28_0004, 1'b0, 1'b0, 5'd0, 32'd0};          // lw $8,4($9)
    rows[2]  = '{32'h0108_5020, 1'b0, 1'b0, 5'd0, 32'd0};          // add $10,$8,$8 -> stall
    rows[3]  = '{32'h0108_5020, 1'b0, 1'b0, 5'd0, 32'd0};          // add issues
    rows[4]  = '{32'h8D28_0004, 1'b0, 1'b0, 5'd0, 32'd0};          // lw $8
    rows[5]  = '{32'hAC08_0000, 1'b0, 1'b0, 5'd0, 32'd0};          // sw $8: rt-only match -> stall
    rows[6]  = '{32'hAC08_0000, 1'b0, 1'b0, 5'd0, 32'd0};
    rows[7]  = '{32'h8D28_0004, 1'b0, 1'b0, 5'd0, 32'd0};          // lw $8
    rows[8]  = '{32'hFC00_0000, 1'b0, 1'b0, 5'd0, 32'd0};          // independent, no stall
    rows[9]  = '{32'h8C00_0000, 1'b0, 1'b0, 5'd0, 32'd0};          // lw $0
    rows[10] = '{32'h0000_0820, 1'b0, 1'b0, 5'd0, 32'd0};          // reads $0, no stall
    foreach (rows[k]) begin
      set_inputs(rows[k]);
      #1;
      checks++;
      if ({stall, id_regrs, id_regrt} !== {exp_stall, exp_r1, exp_r2}) begin
        errors++;
        $display("FAIL load_use_comb[%0d]: got stall=%b rs=%h rt=%h exp stall=%b rs=%h rt=%h", k, stall, id_regrs, id_regrt, exp_stall, exp_r1, exp_r2);
      end
      edge_step();
      exp = sb_q.pop_front();
      checks++;
      if ({sample_a(), stall_cnt} !== {exp, exp_cnt}) begin
        errors++;
        $display("FAIL load_use_idex[%0d]: got %h exp %h", k, {sample_a(), stall_cnt}, {exp, exp_cnt});
      end
    end
  endtask

  task automatic test_flush();
    row_t  rows [4];
    idex_t exp;
    rows[0] = '{32'h8D28_0004, 1'b0, 1'b0, 5'd0, 32'd0};  // lw $8
    rows[1] = '{32'h0108_5020, 1'b1, 1'b0, 5'd0, 32'd0};  // hazard + flush -> bubble, no stall
    rows[2] = '{32'h0108_5020, 1'b0, 1'b0, 5'd0, 32'd0};  // after bubble, issues
    rows[3] = '{32'h00A0_1820, 1'b1, 1'b0, 5'd0, 32'd0};  // plain flush -> bubble
    foreach (rows[k]) begin
      set_inputs(rows[k]);
      #1;
      checks++;
      if ({stall, id_regrs, id_regrt} !== {exp_stall, exp_r1, exp_r2}) begin
        errors++;
        $display("FAIL flush_comb[%0d]: got stall=%b rs=%h rt=%h exp stall=%b rs=%h rt=%h", k, stall, id_regrs, id_regrt, exp_stall, exp_r1, exp_r2);
      end
      edge_step();
      exp = sb_q.pop_front();
      checks++;
      if ({sample_a(), stall_cnt} !== {exp, exp_cnt}) begin
        errors++;
        $display("FAIL flush_idex[%0d]: got %h exp %h", k, {sample_a(), stall_cnt}, {exp, exp_cnt});
      end
    end
  endtask

  task automatic test_bypass();
    row_t  rows [5];
    idex_t exp;
    rows[0] = '{32'hFC00_0000, 1'b0, 1'b1, 5'd7, 32'h0000_1111};  // $7 = old value
    rows[1] = '{32'h00E0_0820, 1'b0, 1'b1, 5'd7, 32'h0000_BEEF};  // write and read $7 together
    rows[2] = '{32'h00E0_0820, 1'b0, 1'b0, 5'd0, 32'd0};          // new value visible
    rows[3] = '{32'h0000_0820, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD};  // write $0 ignored
    rows[4] = '{32'h0000_0820, 1'b0, 1'b0, 5'd0, 32'd0};
    foreach (rows[k]) begin
      set_inputs(rows[k]);
      #1;
      checks++;
      if ({stall, id_regrs, id_regrt} !== {exp_stall, exp_r1, exp_r2}) begin
        errors++;
        $display("FAIL bypass_comb[%0d]: got stall=%b rs=%h rt=%h exp stall=%b rs=%h rt=%h", k, stall, id_regrs, id_regrt, exp_stall, exp_r1, exp_r2);
      end
      edge_step();
      exp = sb_q.pop_front();
      checks++;
      if ({sample_a(), stall_cnt} !== {exp, exp_cnt}) begin
        errors++;
        $display("FAIL bypass_idex[%0d]: got %h exp %h", k, {sample_a(), stall_cnt}, {exp, exp_cnt});
      end
    end
    regwrite = 1'b0;
  endtask

  task automatic test_small_cfg();
    b_regwrite = 1'b1;  b_wrreg = 5'd12;  b_wrdata = 16'hABCD;  b_inst = 32'h0180_0000;
    @(posedge clk); #1;
    b_regwrite = 1'b0; #1;
    checks++;
    if (b_id_regrs !== 16'h0000) begin
      errors++; $display("FAIL small_read12: got %h exp 0000", b_id_regrs);
    end
    b_inst = 32'h0080_0000; #1;
    checks++;
    if (b_id_regrs !== 16'h0000) begin
      errors++; $display("FAIL small_alias4: got %h exp 0000", b_id_regrs);
    end
    b_regwrite = 1'b1;  b_wrreg = 5'd7;  b_wrdata = 16'h7777;
    @(posedge clk); #1;
    b_regwrite = 1'b0;  b_inst = 32'h00E0_0000; #1;
    checks++;
    if (b_id_regrs !== 16'h7777) begin
      errors++; $display("FAIL small_top_reg: got %h exp 7777", b_id_regrs);
    end
    b_inst = 32'hFC00_8001;
    @(posedge clk); #1;
    checks++;
    if (b_seimm !== 16'h8001) begin
      errors++; $display("FAIL small_seimm: got %h exp 8001", b_seimm);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_b;
    for (int k = 0; k < 5; k++) begin
      b_inst = 32'h8C03_0000;  // lw $3,0($0)
      @(posedge clk); #1;
      b_inst = 32'h0060_0820;  // uses $3
      #1;
      checks++;
      if (b_stall !== 1'b1) begin
        errors++; $display("FAIL sat_stall[%0d]: got %b exp 1", k, b_stall);
      end
      @(posedge clk); #1;
      exp_b = (k < 3) ? 2'(k + 1) : 2'd3;
      checks++;
      if ({b_valid, b_stall_cnt} !== {1'b0, exp_b}) begin
        errors++; $display("FAIL sat_cnt[%0d]: got valid=%b cnt=%0d exp valid=0 cnt=%0d", k, b_valid, b_stall_cnt, exp_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    row_t  r;
    idex_t exp;
    r = '{32'hFC00_0000, 1'b0, 1'b1, 5'd5, 32'h0000_1234};
    set_inputs(r); edge_step(); void'(sb_q.pop_front());
    r = '{32'h8D28_0004, 1'b0, 1'b0, 5'd0, 32'd0};
    set_inputs(r); edge_step(); void'(sb_q.pop_front());
    r = '{32'h0108_5020, 1'b0, 1'b0, 5'd0, 32'd0};
    set_inputs(r);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL mid_pre_stall: got %b exp 1", stall);
    end
    #1 reset = 1'b1;
    inst = 32'h00A0_1820;  // reads $5, now cleared
    #1;
    checks++;
    if ({sample_a(), stall, stall_cnt, id_regrs} !== '0) begin
      errors++; $display("FAIL mid_reset_a: got %h exp 0", {sample_a(), stall, stall_cnt, id_regrs});
    end
    checks++;
    if ({b_valid, b_stall_cnt} !== 3'd0) begin
      errors++; $display("FAIL mid_reset_b: got valid=%b cnt=%0d exp 0", b_valid, b_stall_cnt);
    end
    reset_model();
    @(posedge clk); #1;
    reset = 1'b0;
    r = '{32'h00A0_1820, 1'b0, 1'b0, 5'd0, 32'd0};
    set_inputs(r);
    edge_step();
    exp = sb_q.pop_front();
    checks++;
    if ({sample_a(), stall_cnt} !== {exp, exp_cnt}) begin
      errors++; $display("FAIL mid_after: got %h exp %h", {sample_a(), stall_cnt}, {exp, exp_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_flush();
    test_bypass();
    test_small_cfg();
    test_saturate();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, exp 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
